// File: rtl/indication_arbiter_pkg.sv
// Shared types and width helpers for the indication arbiter.
// Optional beat limit is enabled by defining INDARB_BEATLIMIT_EN.
package indarb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } indarb_state_t;

    // Source-index width; a 1-bit minimum keeps NREQ=1 corner builds legal.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int maxbeats);
        return $clog2(maxbeats + 1);
    endfunction

endpackage

// File: rtl/indication_arbiter_if.sv
// Bundle of source, sink, flush and status signals around the indication arbiter.
// Handshake: a beat moves on a rising edge iff X__ENA && X__RDY; a source may
// raise ENA only while its RDY is high, and RDY never depends on ENA.
interface indication_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 128
);
    import indarb_pkg::*;

    logic [NREQ-1:0]       req_pending;
    logic [NREQ-1:0]       req_enq__ENA;
    logic [NREQ-1:0]       req_enq__RDY;
    logic [NREQ*WIDTH-1:0] req_enq_v_data;
    logic [NREQ-1:0]       req_enq_v_last;
    logic                  out_enq__ENA;
    logic                  out_enq__RDY;
    logic [WIDTH-1:0]      out_enq_v_data;
    logic                  out_enq_v_last;
    logic                  clear__ENA;
    logic                  clear__RDY;
    logic                  beat_overflow;
    indarb_state_t         dbg_state;

    modport master (
        output req_pending, req_enq__ENA, req_enq_v_data, req_enq_v_last,
        output out_enq__RDY, clear__ENA,
        input  req_enq__RDY, out_enq__ENA, out_enq_v_data, out_enq_v_last,
        input  clear__RDY, beat_overflow, dbg_state
    );

    modport slave (
        input  req_pending, req_enq__ENA, req_enq_v_data, req_enq_v_last,
        input  out_enq__RDY, clear__ENA,
        output req_enq__RDY, out_enq__ENA, out_enq_v_data, out_enq_v_last,
        output clear__RDY, beat_overflow, dbg_state
    );

endinterface

// File: rtl/indication_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  pending,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && pending[j]) begin
                any       = 1'b1;
                idx       = PW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/indication_arbiter.sv
// Message-atomic round-robin arbiter sharing one indication enq path among NREQ
// sources, with a one-entry output register. Define INDARB_BEATLIMIT_EN to cap beats per message.
module indication_arbiter
    import indarb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 128,
    parameter int MAXBEATS = 16
) (
    input logic CLK,
    input logic RST,
    indication_arbiter_if.slave bus
);

    localparam int PW = ptr_w(NREQ);

    indarb_state_t    state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;

    logic [NREQ-1:0]  pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;

    logic             slot_free;
    logic [NREQ-1:0]  grant_oh;
    logic [PW-1:0]    grant_idx;
    logic             grant_ok;
    logic [NREQ-1:0]  rdy_vec;
    logic             fire;
    logic [WIDTH-1:0] beat_data;
    logic             beat_last;
    logic             last_eff;
    logic [PW-1:0]    next_ptr;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .pending (bus.req_pending),
        .ptr     (ptr),
        .onehot  (pick_oh),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    // A held beat leaving this edge frees the slot for a new one on the same edge.
    assign slot_free = !valid_q || bus.out_enq__RDY;
    assign grant_idx = (state == LOCKED) ? owner : pick_idx;
    assign grant_oh  = (state == LOCKED) ? ({{(NREQ-1){1'b0}}, 1'b1} << owner) : pick_oh;
    assign grant_ok  = (state == LOCKED) || pick_any;
    assign rdy_vec   = (grant_ok && slot_free && !bus.clear__ENA) ? grant_oh : '0;
    assign fire      = |(rdy_vec & bus.req_enq__ENA);
    assign beat_data = bus.req_enq_v_data[int'(grant_idx)*WIDTH +: WIDTH];
    assign beat_last = bus.req_enq_v_last[grant_idx];
    assign next_ptr  = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);

    assign bus.req_enq__RDY   = rdy_vec;
    assign bus.out_enq__ENA   = valid_q && bus.out_enq__RDY;
    assign bus.out_enq_v_data = data_q;
    assign bus.out_enq_v_last = last_q;
    assign bus.clear__RDY     = 1'b1;
    assign bus.dbg_state      = state;

`ifdef INDARB_BEATLIMIT_EN
    localparam int CW = cnt_w(MAXBEATS);

    logic [CW-1:0] beat_cnt;
    logic          limit_hit;
    logic          overflow_q;

    // beat_cnt holds beats already accepted in the current message.
    assign limit_hit = (beat_cnt == CW'(MAXBEATS-1));
    assign last_eff  = beat_last || limit_hit;
    assign bus.beat_overflow = overflow_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            beat_cnt   <= '0;
            overflow_q <= 1'b0;
        end else if (bus.clear__ENA) begin
            beat_cnt   <= '0;
            overflow_q <= 1'b0;
        end else if (fire) begin
            beat_cnt <= last_eff ? '0 : beat_cnt + CW'(1);
            if (limit_hit && !beat_last) overflow_q <= 1'b1;
        end
    end
`else
    assign last_eff          = beat_last;
    assign bus.beat_overflow = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (bus.clear__ENA) begin
            valid_q <= 1'b0;
            state   <= IDLE;
        end else begin
            if (fire) begin
                valid_q <= 1'b1;
                data_q  <= beat_data;
                last_q  <= last_eff;
                if (last_eff) begin
                    state <= IDLE;
                    ptr   <= next_ptr;
                end else begin
                    state <= LOCKED;
                    owner <= grant_idx;
                end
            end else if (bus.out_enq__RDY) begin
                valid_q <= 1'b0;
            end
        end
    end

    a_ena_needs_rdy: assert property (@(posedge CLK) disable iff (RST)
        (bus.req_enq__ENA & ~rdy_vec) == '0);
    a_rdy_onehot0: assert property (@(posedge CLK) disable iff (RST)
        $onehot0(rdy_vec));

endmodule

// File: tb/tb_indication_arbiter.sv
// Self-checking bench for indication_arbiter: directed scenarios plus random traffic
// against a queue-based reference model. Honours INDARB_BEATLIMIT_EN.
module tb_indication_arbiter;
    import indarb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 128;
    localparam int MAXB = 16;
`ifdef INDARB_BEATLIMIT_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;

    indication_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

    indication_arbiter #(.NREQ(NREQ), .WIDTH(W), .MAXBEATS(MAXB)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // stimulus state
    int msg_left[NREQ];
    int beat_no[NREQ];
    bit rand_mode = 1'b0;
    bit refill    = 1'b0;
    bit checking  = 1'b0;

    // observation logs
    int          grant_q[$];
    int          grant_cyc[$];
    logic [16:0] out_log[$];
    int          out_cyc[$];

    // reference model: one-entry output slot as a queue, owner (-1 = none), pointer
    logic [W:0]      exp_q[$];
    int              m_owner = -1;
    int              m_ptr   = 0;
    int              m_cnt   = 0;
    bit              m_ovf   = 1'b0;
    logic [NREQ-1:0] m_acc;
    int              m_idx;
    logic            m_l;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] mdl_rdy();
        logic [NREQ-1:0] r = '0;
        if (bus.clear__ENA) return '0;
        if (exp_q.size() != 0 && !bus.out_enq__RDY) return '0;
        if (m_owner >= 0) begin
            r[m_owner] = 1'b1;
            return r;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (bus.req_pending[(m_ptr + k) % NREQ]) begin
                r[(m_ptr + k) % NREQ] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            exp_q.delete();
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_ovf   = 1'b0;
        end else if (bus.clear__ENA) begin
            exp_q.delete();
            m_owner = -1;
            m_cnt   = 0;
            m_ovf   = 1'b0;
        end else begin
            m_acc = mdl_rdy() & bus.req_enq__ENA;
            if (exp_q.size() != 0 && bus.out_enq__RDY) void'(exp_q.pop_front());
            if (m_acc != '0) begin
                m_idx = 0;
                for (int i = 0; i < NREQ; i++) if (m_acc[i]) m_idx = i;
                m_l = bus.req_enq_v_last[m_idx];
                m_cnt++;
                if (BL && m_cnt == MAXB) begin
                    if (!m_l) m_ovf = 1'b1;
                    m_l = 1'b1;
                end
                if (m_l) begin
                    m_cnt   = 0;
                    m_owner = -1;
                    m_ptr   = (m_idx + 1) % NREQ;
                end else begin
                    m_owner = m_idx;
                end
                exp_q.push_back({m_l, bus.req_enq_v_data[m_idx*W +: W]});
            end
        end
    end

    always @(negedge CLK) begin
        #3;
        if (bus.out_enq__ENA) begin
            out_log.push_back({bus.out_enq_v_last, bus.out_enq_v_data[15:0]});
            out_cyc.push_back(cyc);
        end
        if (checking) begin
            chk("rdy", bus.req_enq__RDY, mdl_rdy());
            chk("out_ena", bus.out_enq__ENA, exp_q.size() != 0 && bus.out_enq__RDY);
            if (exp_q.size() != 0) begin
                chk("out_data", bus.out_enq_v_data, exp_q[0][W-1:0]);
                chk("out_last", bus.out_enq_v_last, exp_q[0][W]);
            end
            chk("overflow", bus.beat_overflow, m_ovf);
            chk("clear_rdy", bus.clear__RDY, 1);
            chk("locked", bus.dbg_state == LOCKED, m_owner >= 0);
        end
    end

    task automatic start_msg(input int src, input int len);
        msg_left[src] = len;
        beat_no[src]  = 0;
    endtask

    task automatic cycle(input bit sink, input bit clr, input int ena_pct);
        logic [NREQ-1:0] ena;
        int c;
        @(negedge CLK);
        c = cyc;
        for (int i = 0; i < NREQ; i++) begin
            if (rand_mode)
                bus.req_pending[i] = (msg_left[i] > 0) ? ($urandom_range(0, 7) != 0)
                                                       : ($urandom_range(0, 15) == 0);
            else
                bus.req_pending[i] = (msg_left[i] > 0);
            bus.req_enq_v_last[i] = (msg_left[i] == 1);
            bus.req_enq_v_data[i*W +: W] = {$urandom(), $urandom(), $urandom(),
                                            16'($urandom()), 8'(beat_no[i]), 8'(i)};
        end
        bus.out_enq__RDY = sink;
        bus.clear__ENA   = clr;
        #1;
        for (int i = 0; i < NREQ; i++)
            ena[i] = bus.req_enq__RDY[i] && (msg_left[i] > 0) && ($urandom_range(0, 99) < ena_pct);
        bus.req_enq__ENA = ena;
        @(posedge CLK);
        for (int i = 0; i < NREQ; i++) begin
            if (ena[i]) begin
                grant_q.push_back(i);
                grant_cyc.push_back(c);
                msg_left[i]--;
                beat_no[i]++;
                if (refill && msg_left[i] == 0) start_msg(i, 1);
            end
        end
    endtask

    function automatic bit busy();
        for (int i = 0; i < NREQ; i++) if (msg_left[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int max, input string name);
        int n = 0;
        while ((busy() || exp_q.size() != 0) && n < max) begin
            cycle(1'b1, 1'b0, 100);
            n++;
        end
        checks++;
        if (busy() || exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_%s actual=%0d cycles required=<%0d", name, n, max);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        checking = 1'b0;
        RST = 1'b1;
        bus.req_pending    = '0;
        bus.req_enq__ENA   = '0;
        bus.req_enq_v_data = '0;
        bus.req_enq_v_last = '0;
        bus.out_enq__RDY   = 1'b1;
        bus.clear__ENA     = 1'b0;
        for (int i = 0; i < NREQ; i++) start_msg(i, 0);
        grant_q.delete(); grant_cyc.delete(); out_log.delete(); out_cyc.delete();
        #2;
        chk("rst_rdy", bus.req_enq__RDY, 0);
        chk("rst_out_ena", bus.out_enq__ENA, 0);
        chk("rst_ovf", bus.beat_overflow, 0);
        chk("rst_clear_rdy", bus.clear__RDY, 1);
        chk("rst_state", bus.dbg_state, IDLE);
        @(negedge CLK);
        RST = 1'b0;
        checking = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // single source, 3-beat message
        do_reset();
        start_msg(0, 3);
        drain(20, "t1");
        chk("t1_ngrant", grant_q.size(), 3);
        chk("t1_nout", out_log.size(), 3);
        if (grant_q.size() == 3 && out_log.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("t1_src", grant_q[k], 0);
                chk("t1_last", out_log[k][16], k == 2);
                chk("t1_latency", out_cyc[k], grant_cyc[k] + 1);
                chk("t1_back2back", grant_cyc[k], grant_cyc[0] + k);
            end
        end
        start_msg(0, 1);
        start_msg(1, 1);
        drain(20, "t1b");
        if (grant_q.size() >= 4) chk("t1_ptr_next", grant_q[3], 1);
        else chk("t1_ptr_ngrant", grant_q.size(), 5);

        // sources 0 and 2, two-beat messages
        do_reset();
        start_msg(0, 2);
        start_msg(2, 2);
        drain(30, "t2");
        chk("t2_ngrant", grant_q.size(), 4);
        if (grant_q.size() == 4) begin
            chk("t2_g0", grant_q[0], 0);
            chk("t2_g1", grant_q[1], 0);
            chk("t2_g2", grant_q[2], 2);
            chk("t2_g3", grant_q[3], 2);
        end

        // all pending, single-beat messages
        do_reset();
        refill = 1'b1;
        for (int i = 0; i < NREQ; i++) start_msg(i, 1);
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 100);
        refill = 1'b0;
        for (int i = 0; i < NREQ; i++) start_msg(i, 0);
        drain(10, "t3");
        chk("t3_ngrant", grant_q.size(), 8);
        if (grant_q.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("t3_order", grant_q[k], k % NREQ);
                chk("t3_cycle", grant_cyc[k], grant_cyc[0] + k);
            end
        end

        // sink stall for 5 cycles with a beat held
        do_reset();
        start_msg(0, 8);
        cycle(1'b1, 1'b0, 100);
        cycle(1'b1, 1'b0, 100);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 100);
            #1;
            chk("t4_stall_rdy", bus.req_enq__RDY, 0);
        end
        drain(30, "t4");
        chk("t4_nout", out_log.size(), 8);
        if (out_log.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("t4_beat", out_log[k][15:8], k);
                chk("t4_last", out_log[k][16], k == 7);
            end
        end

        // flush while locked after the first of four beats
        do_reset();
        start_msg(1, 4);
        cycle(1'b1, 1'b0, 100);
        start_msg(3, 2);
        cycle(1'b0, 1'b1, 100);
        #1;
        chk("t5_state", bus.dbg_state, IDLE);
        chk("t5_valid", bus.out_enq__ENA, 0);
        drain(30, "t5");
        chk("t5_ngrant", grant_q.size(), 6);
        chk("t5_nout", out_log.size(), 5);
        if (grant_q.size() == 6) begin
            chk("t5_g1", grant_q[1], 1);
            chk("t5_g4", grant_q[4], 3);
        end
        if (out_log.size() == 5) begin
            chk("t5_first_src", out_log[0][7:0], 1);
            chk("t5_first_beat", out_log[0][15:8], 1);
        end

        // 20-beat message against the beat limit
        do_reset();
        start_msg(2, 20);
        drain(60, "t6");
        chk("t6_nout", out_log.size(), 20);
        if (out_log.size() == 20) begin
            for (int k = 0; k < 20; k++)
                chk("t6_last", out_log[k][16], (k == 19) || (BL && k == MAXB-1));
        end
        chk("t6_overflow", bus.beat_overflow, BL);

        // random traffic with stalls, drops of pending and flushes
        do_reset();
        rand_mode = 1'b1;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (msg_left[i] == 0 && $urandom_range(0, 5) == 0)
                    start_msg(i, ($urandom_range(0, 9) == 0) ? $urandom_range(17, 20)
                                                             : $urandom_range(1, 5));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 80);
        end
        rand_mode = 1'b0;
        drain(400, "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
